unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Sequences one shared single-ported memory between two requesters of the pipelined processor: instruction fetch (IF) and the MEM-stage data port (DM).
- Grants one request at a time and drives the memory for a fixed number of access cycles.
- Pulses a one-cycle ready with the captured read data.
- Data requests have priority, with a starvation override so IF is never locked out.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- WAIT_CYCLES, 2, cycles mem_en is held per access; legal range 1..15
- STARVE_LIMIT, 4, consecutive DM grants with IF pending before IF is forced to win; 0 disables the override

Ports:
- Clk  in  1  clock; all state updates on the negative edge, matching the pipeline registers
- Rst  in  1  asynchronous reset, active-high
- if_req  in  1  IF read request; held until if_ready
- if_addr  in  ADDR_W  IF read address
- if_ready  out  1  one-cycle pulse: IF access complete
- if_rdata  out  DATA_W  IF read data; valid while if_ready=1, held until the next IF completion
- dm_req  in  1  DM request; held until dm_ready
- dm_we  in  1  1=write, 0=read
- dm_addr  in  ADDR_W  DM address
- dm_wdata  in  DATA_W  DM write data
- dm_ready  out  1  one-cycle pulse: DM access complete
- dm_rdata  out  DATA_W  DM read data; valid while dm_ready=1, held until the next DM read completion
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the last enabled cycle
- busy  out  1  1 while the state is not IDLE

Behaviour:
Reset
- State=IDLE; starve_cnt=0.
- All outputs 0: if_ready, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, busy.
- Assertion mid-operation aborts immediately:
  - mem_en and mem_we drop asynchronously.
  - No ready pulse is issued for the aborted access.

FSM: IDLE -> ACCESS -> DONE -> IDLE
- IDLE:
  - If any request is pending, arbitrate, latch grant/addr/we/wdata into registers, load wait_cnt=WAIT_CYCLES-1 and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_en=1; mem_we=latched dm_we (always 0 for IF); mem_addr and mem_wdata come from the latched registers.
  - Decrement wait_cnt each cycle.
  - At wait_cnt=0, capture mem_rdata into if_rdata or dm_rdata (reads only) and go to DONE.
- DONE:
  - Pulse the granted requester's ready for one cycle; mem_en=0.
  - Always return to IDLE; no re-arbitration in DONE, because the requester still shows req=1 that cycle.

Latency
- Request sampled in IDLE at edge t.
- mem_en is high for exactly WAIT_CYCLES cycles.
- ready is high in cycle t+WAIT_CYCLES+1.
- Minimum spacing between grants is WAIT_CYCLES+2 cycles.

Arbitration (IDLE only)
- Only DM requesting: grant DM. Only IF requesting: grant IF.
- Both requesting: grant DM, unless STARVE_LIMIT!=0 and starve_cnt==STARVE_LIMIT, in which case grant IF.
- starve_cnt increments, saturating at STARVE_LIMIT, on each DM grant made while if_req=1.
- starve_cnt clears on any IF grant.

Boundaries
- If the requester drops req mid-ACCESS, the access still completes and ready still pulses. Memory contents remain consistent.
- A write's dm_ready pulse has dm_rdata unchanged.
- WAIT_CYCLES=1: a single ACCESS cycle.
- Address and data are latched at grant; input changes during ACCESS are ignored.

Decomposition:
- Shared package unified_mem_pkg:
  - state encoding: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10
  - grant encoding: GNT_IF=1'b0, GNT_DM=1'b1
- One sub-module, arb_starve_counter:
  - saturating counter with inc/clr inputs and an at_limit output
  - parameter STARVE_LIMIT
  - uses the same Clk/Rst

Test Plan (WAIT_CYCLES=2, STARVE_LIMIT=2, memory model with 2-cycle read):
- Assert Rst during idle and check all outputs -> every output 0, busy=0.
- IF read: if_addr=0x100, mem[0x100]=0xDEADBEEF -> mem_en high 2 cycles with mem_addr=0x100 and mem_we=0; if_ready pulses on the 3rd cycle after sampling with if_rdata=0xDEADBEEF; dm_ready stays 0.
- if_req and dm_req rise together -> DM is served first and dm_ready pulses; IF is granted on the next IDLE and if_ready pulses 4 cycles after dm_ready.
- DM write: addr 0x200, wdata 0x12345678, then DM read of 0x200 -> mem_we high 2 cycles; dm_ready pulses; the read returns dm_rdata=0x12345678.
- Starvation: dm_req re-issued continuously while if_req is held -> 2 DM grants, then the 3rd grant goes to IF; starve_cnt returns to 0 and the next grant is DM.
- Rst pulsed in the first ACCESS cycle of a DM write -> mem_en and mem_we drop immediately; no dm_ready pulse; after reset release, a new IF request completes normally with standard latency.

Source files
------------

// File: rtl/unified_mem_pkg.sv
// Shared types for the unified memory arbiter.
// Purpose : state and grant encodings plus a width helper for the starvation counter.
// Ports   : none (package).
package unified_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

    // Access-cycle countdown width; WAIT_CYCLES is limited to 1..15.
    localparam int unsigned WAIT_CNT_W = 4;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of DM grants made while IF was also waiting.
// Purpose : tells the arbiter when IF must win the next contested grant.
// Ports   : Clk        clock (negative edge active)
//           Rst        asynchronous reset, active-high
//           i_inc      DM granted while IF pending
//           i_clr      IF granted
//           o_at_limit count has reached STARVE_LIMIT (never set when STARVE_LIMIT=0)
module arb_starve_counter
    import unified_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // With STARVE_LIMIT=0 the counter is pinned at zero and the override never fires.
    assign o_at_limit = (STARVE_LIMIT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and the data port (DM).
// Purpose : one access at a time, fixed WAIT_CYCLES enable window, one-cycle ready pulse,
//           DM priority with a starvation override in favour of IF.
// Ports   : Clk, Rst                          clock (negedge active), async active-high reset
//           if_req/if_addr -> if_ready/if_rdata    IF read port
//           dm_req/dm_we/dm_addr/dm_wdata -> dm_ready/dm_rdata   DM read/write port
//           mem_en/mem_we/mem_addr/mem_wdata, mem_rdata          shared memory port
//           busy                               state is not IDLE
module unified_mem_arbiter
    import unified_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    state_e                  r_state;
    grant_e                  r_grant;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic                    r_if_ready;
    logic                    r_dm_ready;
    logic [DATA_W-1:0]       r_if_rdata;
    logic [DATA_W-1:0]       r_dm_rdata;

    logic w_any_req;
    logic w_grant_dm;
    logic w_at_limit;
    logic w_starve_inc;
    logic w_starve_clr;
    logic w_arbitrate;

    assign w_any_req   = if_req | dm_req;
    // DM wins unless IF is also waiting and has already been passed over STARVE_LIMIT times.
    assign w_grant_dm  = dm_req & ~(if_req & w_at_limit);
    assign w_arbitrate = (r_state == IDLE) & w_any_req;
    assign w_starve_inc = w_arbitrate & w_grant_dm & if_req;
    assign w_starve_clr = w_arbitrate & ~w_grant_dm;

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_inc      (w_starve_inc),
        .i_clr      (w_starve_clr),
        .o_at_limit (w_at_limit)
    );

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= IDLE;
            r_grant     <= GNT_IF;
            r_wait_cnt  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant     <= w_grant_dm ? GNT_DM : GNT_IF;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_grant_dm & dm_we;
                        r_mem_addr  <= w_grant_dm ? dm_addr : if_addr;
                        r_mem_wdata <= w_grant_dm ? dm_wdata : '0;
                        r_wait_cnt  <= WAIT_LOAD;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_wait_cnt == '0) begin
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        // Ready is set here so it is high throughout DONE.
                        if (r_grant == GNT_IF) begin
                            r_if_rdata <= mem_rdata;
                            r_if_ready <= 1'b1;
                        end else begin
                            if (!r_mem_we) begin
                                r_dm_rdata <= mem_rdata;
                            end
                            r_dm_ready <= 1'b1;
                        end
                        r_state <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                // Requester still shows req while ready is high, so never re-arbitrate here.
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (WAIT_CYCLES=2, STARVE_LIMIT=2).
module tb_unified_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:4095];

    always #5 Clk = ~Clk;

    unified_mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .WAIT_CYCLES  (2),
        .STARVE_LIMIT (2)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ready  (dm_ready),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Memory model: read data registered on the posedge inside the first enabled cycle,
    // so it is valid by the end of the second (last) enabled cycle.
    always @(posedge Clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[11:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next active (negative) edge; outputs are stable until the following one.
    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    logic [31:0] exp_addr;
    logic        exp_dm;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h100] = 32'hDEADBEEF;
        mem[12'h300] = 32'hCAFEF00D;
        mem_rdata = 32'h0;
        Rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        // Reset in idle: everything zero.
        #2;
        chk("rst if_ready",  {31'b0, if_ready}, 32'h0);
        chk("rst dm_ready",  {31'b0, dm_ready}, 32'h0);
        chk("rst mem_en",    {31'b0, mem_en},   32'h0);
        chk("rst mem_we",    {31'b0, mem_we},   32'h0);
        chk("rst mem_addr",  mem_addr,          32'h0);
        chk("rst mem_wdata", mem_wdata,         32'h0);
        chk("rst if_rdata",  if_rdata,          32'h0);
        chk("rst dm_rdata",  dm_rdata,          32'h0);
        chk("rst busy",      {31'b0, busy},     32'h0);
        step();
        Rst = 1'b0;
        step();
        chk("idle busy", {31'b0, busy}, 32'h0);

        // IF read of 0x100.
        if_req = 1'b1; if_addr = 32'h100;
        step();
        chk("if acc1 mem_en",   {31'b0, mem_en},   32'h1);
        chk("if acc1 mem_addr", mem_addr,          32'h100);
        chk("if acc1 mem_we",   {31'b0, mem_we},   32'h0);
        chk("if acc1 busy",     {31'b0, busy},     32'h1);
        step();
        chk("if acc2 mem_en",   {31'b0, mem_en},   32'h1);
        chk("if acc2 if_ready", {31'b0, if_ready}, 32'h0);
        step();
        chk("if done if_ready", {31'b0, if_ready}, 32'h1);
        chk("if done if_rdata", if_rdata,          32'hDEADBEEF);
        chk("if done mem_en",   {31'b0, mem_en},   32'h0);
        chk("if done dm_ready", {31'b0, dm_ready}, 32'h0);
        if_req = 1'b0;
        step();
        chk("if idle if_ready", {31'b0, if_ready}, 32'h0);
        chk("if idle busy",     {31'b0, busy},     32'h0);
        chk("if rdata held",    if_rdata,          32'hDEADBEEF);

        // Simultaneous requests: DM first, IF four cycles later.
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        step();
        chk("both grant addr", mem_addr, 32'h300);
        step();
        step();
        chk("both dm_ready", {31'b0, dm_ready}, 32'h1);
        chk("both if_ready", {31'b0, if_ready}, 32'h0);
        chk("both dm_rdata", dm_rdata,          32'hCAFEF00D);
        dm_req = 1'b0;
        step();
        step();
        chk("both if grant addr", mem_addr,        32'h100);
        chk("both if grant en",   {31'b0, mem_en}, 32'h1);
        step();
        step();
        chk("both if_ready late", {31'b0, if_ready}, 32'h1);
        chk("both if_rdata",      if_rdata,          32'hDEADBEEF);
        if_req = 1'b0;
        step();

        // DM write 0x200, inputs changed mid-access must be ignored.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
        step();
        chk("wr acc1 mem_we",    {31'b0, mem_we}, 32'h1);
        chk("wr acc1 mem_addr",  mem_addr,        32'h200);
        chk("wr acc1 mem_wdata", mem_wdata,       32'h12345678);
        dm_addr = 32'h204; dm_wdata = 32'hFFFFFFFF;
        step();
        chk("wr acc2 mem_we",    {31'b0, mem_we}, 32'h1);
        chk("wr acc2 mem_addr",  mem_addr,        32'h200);
        chk("wr acc2 mem_wdata", mem_wdata,       32'h12345678);
        step();
        chk("wr dm_ready", {31'b0, dm_ready}, 32'h1);
        chk("wr dm_rdata unchanged", dm_rdata, 32'hCAFEF00D);
        chk("wr mem_we low", {31'b0, mem_we}, 32'h0);
        dm_req = 1'b0;
        step();
        chk("wr mem[0x204] untouched", mem[12'h204], 32'h0);

        // DM read back of 0x200.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        step();
        step();
        step();
        chk("rd dm_ready", {31'b0, dm_ready}, 32'h1);
        chk("rd dm_rdata", dm_rdata,          32'h12345678);
        dm_req = 1'b0;
        step();

        // Starvation: both held; grants go DM, DM, IF, DM.
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        for (int g = 0; g < 4; g++) begin
            exp_dm   = (g != 2);
            exp_addr = exp_dm ? 32'h300 : 32'h100;
            step();
            chk($sformatf("starve g%0d addr", g), mem_addr, exp_addr);
            step();
            step();
            chk($sformatf("starve g%0d dm_ready", g), {31'b0, dm_ready}, {31'b0, exp_dm});
            chk($sformatf("starve g%0d if_ready", g), {31'b0, if_ready}, {31'b0, ~exp_dm});
            if (g == 2) if_req = 1'b0;
            if (g == 3) dm_req = 1'b0;
            step();
        end

        // Reset during the first ACCESS cycle of a DM write.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h240; dm_wdata = 32'hAAAA5555;
        step();
        chk("abort pre mem_we", {31'b0, mem_we}, 32'h1);
        Rst = 1'b1;
        #1;
        chk("abort mem_en",   {31'b0, mem_en}, 32'h0);
        chk("abort mem_we",   {31'b0, mem_we}, 32'h0);
        chk("abort busy",     {31'b0, busy},   32'h0);
        chk("abort dm_rdata", dm_rdata,        32'h0);
        dm_req = 1'b0; dm_we = 1'b0;
        step();
        chk("abort no dm_ready", {31'b0, dm_ready}, 32'h0);
        Rst = 1'b0;
        step();
        chk("abort no dm_ready2", {31'b0, dm_ready}, 32'h0);
        chk("abort mem[0x240]", mem[12'h240], 32'h0);

        // Post-reset IF read at standard latency.
        if_req = 1'b1; if_addr = 32'h100;
        step();
        chk("post acc1 mem_en", {31'b0, mem_en}, 32'h1);
        step();
        chk("post acc2 if_ready", {31'b0, if_ready}, 32'h0);
        step();
        chk("post if_ready", {31'b0, if_ready}, 32'h1);
        chk("post if_rdata", if_rdata,          32'hDEADBEEF);
        chk("post dm_ready", {31'b0, dm_ready}, 32'h0);
        if_req = 1'b0;
        step();
        chk("post idle busy", {31'b0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
